// File: rtl/seg7_mode_ctrl.sv
// seg7_mode_ctrl: button synchroniser, debouncer and short/long press
// classifier driving the 7-segment animator's mode and reset inputs.
module seg7_mode_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned LONG_CYCLES     = 25000,
  parameter int unsigned AUTO_CYCLES     = 50000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_i,
  output logic [0:0] mode_o,
  output logic       auto_o,
  output logic       anim_rst_o,
  output logic       long_o
);

  localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] LONG_LAST = 16'(LONG_CYCLES - 1);
  localparam logic [15:0] AUTO_LAST = 16'(AUTO_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        s1;
  logic        s2;
  logic        db;
  logic [15:0] dcnt;
  logic [15:0] hcnt;
  logic [15:0] acnt;
  logic        short_ev;
  logic        long_ev;
  logic        auto_ev;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      dcnt <= '0;
    end else begin
      s1 <= btn_i;
      s2 <= s1;
      if (s2 == db) begin
        dcnt <= '0;
      end else if (dcnt == DB_LAST) begin
        db   <= s2;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (db) state_nx = HELD;
      HELD: begin
        if (!db)                    state_nx = IDLE;
        else if (hcnt == LONG_LAST) state_nx = LONG;
      end
      LONG: if (!db) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Auto toggles need IDLE and button events need HELD, so they never coincide.
  always_comb begin
    short_ev = 1'b0;
    long_ev  = 1'b0;
    auto_ev  = 1'b0;
    if (state == HELD) begin
      short_ev = !db;
      long_ev  = db && (hcnt == LONG_LAST);
    end
    if (state == IDLE && auto_o) begin
      auto_ev = (acnt == AUTO_LAST);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hcnt <= '0;
      acnt <= '0;
    end else begin
      if (state != HELD)       hcnt <= '0;
      else if (db && !long_ev) hcnt <= hcnt + 16'd1;
      if (!auto_o || state != IDLE || auto_ev) acnt <= '0;
      else                                     acnt <= acnt + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mode_o     <= 1'b0;
      auto_o     <= 1'b0;
      anim_rst_o <= 1'b1;
      long_o     <= 1'b0;
    end else begin
      mode_o     <= mode_o ^ (short_ev | auto_ev);
      auto_o     <= auto_o ^ long_ev;
      anim_rst_o <= short_ev | auto_ev;
      long_o     <= long_ev;
    end
  end

endmodule
